// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock period meter.
//   meter_state_e : FSM state encoding (idle, armed for first edge, measuring)
//   DefCntW       : default counter/result width
//   DefTimeoutCyc : default timeout limit in clk cycles (used with CLK_METER_TIMEOUT_EN)
package clk_meter_pkg;

  localparam int unsigned DefCntW       = 32;
  localparam int unsigned DefTimeoutCyc = 1000000;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeas
  } meter_state_e;

endpackage

// File: rtl/edge_sync.sv
// Synchronizer and edge detector for the asynchronous signal under measurement.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   sig_in     : asynchronous input
//   rise, fall : single-cycle pulses for a rising / falling edge of the synchronized signal
// Both pulses trail sig_in by the same three-register delay, so intervals between
// edges are preserved exactly.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q, sync3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;
  assign fall = ~sync2_q & sync3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow signal in clk cycles.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   sig_in     : divided clock under measurement, asynchronous to clk
//   start      : one-cycle request to begin a measurement (ignored while busy)
//   busy       : high while a measurement is armed or running
//   valid      : one-cycle pulse when period/high_time carry a new result
//   period     : clk cycles between two consecutive rising edges (saturating)
//   high_time  : clk cycles the signal was high within that period
//   timeout    : one-cycle pulse when a measurement is abandoned
// Build option: define CLK_METER_TIMEOUT_EN to abort after TIMEOUT_CYC cycles without
// any edge; otherwise timeout is tied low and the meter waits indefinitely.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic rise, fall;
  logic abort;

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

`ifdef CLK_METER_TIMEOUT_EN
  localparam int unsigned      WaitW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYC - 1);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q;

  // Counts cycles since entering ARM or since the last edge; wraps into an abort.
  always_comb begin
    wait_d = wait_q;
    abort  = 1'b0;
    if (state_q == StIdle || rise || fall) begin
      wait_d = '0;
    end else if (wait_q == WaitLast) begin
      wait_d = '0;
      abort  = 1'b1;
    end else begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= abort;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_d      = high_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StArm;
      end
      StArm: begin
        // Only a detected edge starts the count; a level already high is ignored.
        if (rise) begin
          cnt_d   = CntOne;
          state_d = StMeas;
        end else if (abort) begin
          state_d = StIdle;
        end
      end
      StMeas: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;
        if (fall) high_d = cnt_q;
        if (rise) begin
          period_d    = cnt_q;
          high_time_d = high_q;
          valid_d     = 1'b1;
          state_d     = StIdle;
        end else if (abort) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      high_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_q      <= high_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign valid     = valid_q;
  assign period    = period_q;
  assign high_time = high_time_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: a full-width and a 4-bit instance share all inputs.
// Stimulus drives square waves with random high/low lengths and issues starts at
// random phases; each accepted start pushes the expected result into per-instance
// queues, and a monitor pops and compares on every valid pulse.
module tb_clk_period_meter;

  localparam int unsigned CntW       = 32;
  localparam int unsigned SmallW     = 4;
  localparam int unsigned TimeoutCyc = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_in;
  logic        start;
  logic        busy, valid, timeout;
  logic [31:0] period, high_time;
  logic        busy_s, valid_s, timeout_s;
  logic [3:0]  period_s, high_time_s;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_per_q[$];
  logic [31:0] exp_high_q[$];
  logic [31:0] exps_per_q[$];
  logic [31:0] exps_high_q[$];
  logic [31:0] last_per = 0, last_high = 0, lasts_per = 0, lasts_high = 0;

  int valids_seen   = 0;
  int timeouts_seen = 0;
  int exp_timeouts  = 0;
  int hi_len = 5, lo_len = 5, ph = 0;

  clk_period_meter #(
    .CNT_W       (CntW),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .start     (start),
    .busy      (busy),
    .valid     (valid),
    .period    (period),
    .high_time (high_time),
    .timeout   (timeout)
  );

  clk_period_meter #(
    .CNT_W       (SmallW),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .start     (start),
    .busy      (busy_s),
    .valid     (valid_s),
    .period    (period_s),
    .high_time (high_time_s),
    .timeout   (timeout_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: a counter of width w cannot exceed all-ones.
  function automatic logic [31:0] sat(input int unsigned v, input int unsigned w);
    longint unsigned m;
    m = (64'd1 << w) - 64'd1;
    if (64'(v) > m) return m[31:0];
    return v;
  endfunction

  // Any full cycle of a constant square wave yields period h+l and high time h.
  task automatic push_exp(input int unsigned h, input int unsigned l);
    exp_per_q.push_back(sat(h + l, CntW));
    exp_high_q.push_back(sat(h, CntW));
    exps_per_q.push_back(sat(h + l, SmallW));
    exps_high_q.push_back(sat(h, SmallW));
  endtask

  task automatic step(input logic st);
    sig_in = (ph < hi_len);
    start  = st;
    @(posedge clk);
    #1;
    ph = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
  endtask

  task automatic run_txn(input int h, input int l, input int ofs, input bit restart,
                         input bit chain);
    int  target;
    int  budget;
    int  restart_at;
    bit  chained;
    logic st;
    hi_len = h;
    lo_len = l;
    ph     = 0;
    repeat (2 * (h + l) + 4) step(1'b0);
    repeat (ofs) step(1'b0);
    push_exp(h, l);
    target     = valids_seen + 1;
    budget     = 4 * (h + l) + 20;
    restart_at = $urandom_range(0, h + l - 1);
    chained    = 1'b0;
    step(1'b1);
    for (int c = 0; c < budget && valids_seen < target; c++) begin
      st = 1'b0;
      if (restart && c == restart_at) st = 1'b1;
      // Start issued during the valid cycle must be accepted.
      if (chain && !chained && valid) begin
        st      = 1'b1;
        chained = 1'b1;
        push_exp(h, l);
        target++;
      end
      step(st);
    end
    check("valid_within_budget", 32'(valids_seen), 32'(target));
    repeat (h + l + 5) step(1'b0);
  endtask

  // Monitor: pops expectations on valid, otherwise results must hold.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_per   = 0;
        last_high  = 0;
        lasts_per  = 0;
        lasts_high = 0;
      end else begin
        if (valid) begin
          valids_seen++;
          check("busy_at_valid", 32'(busy), 32'd0);
          if (exp_per_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: actual=1 required=0");
          end else begin
            e = exp_per_q.pop_front();
            check("period", period, e);
            last_per = e;
            e = exp_high_q.pop_front();
            check("high_time", high_time, e);
            last_high = e;
          end
        end else begin
          check("period_hold", period, last_per);
          check("high_time_hold", high_time, last_high);
        end
        if (valid_s) begin
          if (exps_per_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid_small: actual=1 required=0");
          end else begin
            e = exps_per_q.pop_front();
            check("period_small", 32'(period_s), e);
            lasts_per = e;
            e = exps_high_q.pop_front();
            check("high_time_small", 32'(high_time_s), e);
            lasts_high = e;
          end
        end else begin
          check("period_small_hold", 32'(period_s), lasts_per);
          check("high_time_small_hold", 32'(high_time_s), lasts_high);
        end
        if (timeout) timeouts_seen++;
        if (timeout_s) timeouts_seen++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_period"}, period, 32'd0);
    check({tag, "_high_time"}, high_time, 32'd0);
    check({tag, "_busy_s"}, 32'(busy_s), 32'd0);
    check({tag, "_period_s"}, 32'(period_s), 32'd0);
    check({tag, "_high_time_s"}, 32'(high_time_s), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    start  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    run_txn(5, 5, 3, 1'b0, 1'b0);    // divide-by-10, 50% duty
    run_txn(3, 7, 7, 1'b0, 1'b0);    // start while signal already high
    run_txn(5, 5, 0, 1'b1, 1'b0);    // extra start while busy
    run_txn(10, 10, 2, 1'b0, 1'b0);  // small instance saturates to 15 / 10
    run_txn(4, 6, 2, 1'b0, 1'b1);    // start coincident with valid

    // Reset four cycles into a measurement.
    hi_len = 5;
    lo_len = 5;
    ph     = 0;
    repeat (24) step(1'b0);
    repeat (5) step(1'b0);
    step(1'b1);
    repeat (7) step(1'b0);
    check("busy_before_reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) step(1'b0);
    check("busy_after_reset", 32'(busy), 32'd0);

    repeat (25) begin
      run_txn($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(0, 23),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef CLK_METER_TIMEOUT_EN
    begin
      int found;
      hi_len = 0;
      lo_len = 1;
      ph     = 0;
      found  = -1;
      repeat (5) step(1'b0);
      step(1'b1);
      for (int c = 0; c < 150 && found < 0; c++) begin
        step(1'b0);
        if (timeout) begin
          found = c;
          check("timeout_small_same_cycle", 32'(timeout_s), 32'd1);
          check("busy_at_timeout", 32'(busy), 32'd0);
        end
      end
      // Timeout lands 100 cycles after the FSM enters ARM.
      check("timeout_cycle", 32'(found), 32'd99);
      exp_timeouts = 2;
      repeat (10) step(1'b0);
    end
`endif

    repeat (10) step(1'b0);
    check("queue_drained", 32'(exp_per_q.size()), 32'd0);
    check("timeout_pulses", 32'(timeouts_seen), 32'(exp_timeouts));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
